// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding for the bit-serial arithmetic blocks
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             cell_bout;
    logic [WIDTH-1:0] sh_next;

    full_subtractor u_cell (
        .x    (opa_q[0]),
        .y    (opb_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (cell_bout)
    );

    // New bit enters at the MSB so the LSB-first stream lands in order after WIDTH shifts.
    assign sh_next = WIDTH'({bit_d, sh_q} >> 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sh_d     = sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d    = a;
                    opb_d    = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                borrow_d = cell_bout;
                sh_d     = sh_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = sh_next;
                    bout_d  = cell_bout;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sh_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sh_q     <= sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule
